// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC coefficient scan front end.
package cavlc_pkg;
    localparam int BLK_N  = 16;
    localparam int T1_MAX = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    typedef logic signed [7:0] coef_t;
endpackage

// File: rtl/cavlc_t1_tracker.sv
// Trailing-ones tracker: counts the leading run of +/-1 seen in reverse scan order.
module cavlc_t1_tracker #(
    parameter int COEF_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     valid,
    input  logic signed [COEF_W-1:0] coef,
    output logic [1:0]               t1_cnt,
    output logic                     t1_stop,
    output logic                     is_t1
);
    import cavlc_pkg::*;

    localparam logic signed [COEF_W-1:0] POS_ONE = COEF_W'(1);
    localparam logic signed [COEF_W-1:0] NEG_ONE = '1;

    logic [1:0] cnt_reg;
    logic       stop_reg;
    logic       coef_pm1;

    assign coef_pm1 = (coef == POS_ONE) || (coef == NEG_ONE);
    assign t1_cnt   = cnt_reg;
    // The run ends either on a non-unit level or once three ones are held.
    assign t1_stop  = stop_reg | (cnt_reg == 2'(T1_MAX));
    assign is_t1    = valid & coef_pm1 & ~t1_stop;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg  <= '0;
            stop_reg <= 1'b0;
        end else if (valid && coef != '0) begin
            if (is_t1) begin
                cnt_reg <= cnt_reg + 2'd1;
            end else begin
                stop_reg <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/cavlc_scan_ctrl.sv
// Reverse-zigzag scan sequencer: reads a 4x4 block, classifies coefficients,
// feeds the level list and hands TotalCoeff/TrailingOnes/TotalZeros downstream.
module cavlc_scan_ctrl #(
    parameter int COEF_W = 8,
    parameter int BLK_N  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     blk_valid_i,
    output logic                     blk_ready_o,
    output logic                     coef_rd_o,
    output logic [3:0]               coef_addr_o,
    input  logic signed [COEF_W-1:0] coef_i,
    output logic                     lvl_clr_o,
    output logic                     lvl_we_o,
    output logic signed [COEF_W-1:0] lvl_coef_o,
    output logic [1:0]               t1_cnt_o,
    output logic                     t1_stop_o,
    output logic                     sum_valid_o,
    input  logic                     sum_ready_i,
    output logic [4:0]               total_coeff_o,
    output logic [1:0]               trailing_ones_o,
    output logic [3:0]               total_zeros_o
);
    import cavlc_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(BLK_N - 1);

    state_t     state_reg, state_next;
    logic [3:0] scan_cnt_reg;
    logic       rd_valid_reg;
    logic       seen_reg;
    logic [4:0] total_coeff_reg;
    logic [3:0] total_zeros_reg;

    logic       clr;
    logic       coef_nz;
    logic       lvl_we;
    logic       is_t1;
    logic       t1_stop;
    logic [1:0] t1_cnt;

    assign clr     = (state_reg == CLEAR);
    assign coef_nz = (coef_i != '0);
    // rd_valid_reg marks the cycle where coef_i carries the previous read.
    assign lvl_we  = rd_valid_reg & coef_nz & ~is_t1;

    cavlc_t1_tracker #(.COEF_W(COEF_W)) t1_tracker (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .valid   (rd_valid_reg),
        .coef    (coef_i),
        .t1_cnt  (t1_cnt),
        .t1_stop (t1_stop),
        .is_t1   (is_t1)
    );

    always_comb begin
        state_next      = state_reg;
        blk_ready_o     = 1'b0;
        coef_rd_o       = 1'b0;
        coef_addr_o     = '0;
        lvl_clr_o       = 1'b0;
        lvl_we_o        = 1'b0;
        lvl_coef_o      = '0;
        t1_cnt_o        = '0;
        t1_stop_o       = 1'b0;
        sum_valid_o     = 1'b0;
        total_coeff_o   = '0;
        trailing_ones_o = '0;
        total_zeros_o   = '0;
        case (state_reg)
            IDLE:    if (blk_valid_i) state_next = CLEAR;
            CLEAR:   state_next = SCAN;
            SCAN:    if (scan_cnt_reg == LAST_IDX) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    if (sum_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Outputs are forced low for the whole reset cycle.
        if (!rst) begin
            blk_ready_o     = (state_reg == IDLE);
            coef_rd_o       = (state_reg == SCAN);
            coef_addr_o     = (state_reg == SCAN) ? (LAST_IDX - scan_cnt_reg) : 4'd0;
            lvl_clr_o       = clr;
            lvl_we_o        = lvl_we;
            lvl_coef_o      = lvl_we ? coef_i : '0;
            t1_cnt_o        = t1_cnt;
            t1_stop_o       = t1_stop;
            sum_valid_o     = (state_reg == DONE);
            total_coeff_o   = total_coeff_reg;
            trailing_ones_o = t1_cnt;
            total_zeros_o   = total_zeros_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            scan_cnt_reg    <= '0;
            rd_valid_reg    <= 1'b0;
            seen_reg        <= 1'b0;
            total_coeff_reg <= '0;
            total_zeros_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rd_valid_reg <= (state_reg == SCAN);
            if (state_reg == CLEAR) begin
                scan_cnt_reg    <= '0;
                seen_reg        <= 1'b0;
                total_coeff_reg <= '0;
                total_zeros_reg <= '0;
            end else begin
                if (state_reg == SCAN) scan_cnt_reg <= scan_cnt_reg + 4'd1;
                // Zeros only count once the highest-frequency nonzero has been passed.
                if (rd_valid_reg) begin
                    if (coef_nz) begin
                        total_coeff_reg <= total_coeff_reg + 5'd1;
                        seen_reg        <= 1'b1;
                    end else if (seen_reg) begin
                        total_zeros_reg <= total_zeros_reg + 4'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cavlc_scan_ctrl.sv
// Self-checking bench for cavlc_scan_ctrl against a block-level CAVLC reference model.
module tb_cavlc_scan_ctrl;
    typedef logic signed [7:0] blk_t [16];

    logic              clk = 1'b0;
    logic              rst;
    logic              blk_valid_i;
    logic              blk_ready_o;
    logic              coef_rd_o;
    logic [3:0]        coef_addr_o;
    logic signed [7:0] coef_i;
    logic              lvl_clr_o;
    logic              lvl_we_o;
    logic signed [7:0] lvl_coef_o;
    logic [1:0]        t1_cnt_o;
    logic              t1_stop_o;
    logic              sum_valid_o;
    logic              sum_ready_i;
    logic [4:0]        total_coeff_o;
    logic [1:0]        trailing_ones_o;
    logic [3:0]        total_zeros_o;

    cavlc_scan_ctrl #(.COEF_W(8), .BLK_N(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .blk_valid_i     (blk_valid_i),
        .blk_ready_o     (blk_ready_o),
        .coef_rd_o       (coef_rd_o),
        .coef_addr_o     (coef_addr_o),
        .coef_i          (coef_i),
        .lvl_clr_o       (lvl_clr_o),
        .lvl_we_o        (lvl_we_o),
        .lvl_coef_o      (lvl_coef_o),
        .t1_cnt_o        (t1_cnt_o),
        .t1_stop_o       (t1_stop_o),
        .sum_valid_o     (sum_valid_o),
        .sum_ready_i     (sum_ready_i),
        .total_coeff_o   (total_coeff_o),
        .trailing_ones_o (trailing_ones_o),
        .total_zeros_o   (total_zeros_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Coefficient buffer with one-cycle registered read.
    blk_t mem;
    always @(posedge clk) if (coef_rd_o) coef_i <= mem[coef_addr_o];

    logic signed [7:0] got_lvl[$];
    logic [3:0]        got_addr[$];
    int                clr_cnt;
    always @(negedge clk) begin
        if (lvl_we_o)  got_lvl.push_back(lvl_coef_o);
        if (lvl_clr_o) clr_cnt++;
        if (coef_rd_o) got_addr.push_back(coef_addr_o);
    end

    int n_tests = 0;
    int n_fail  = 0;

    int                exp_tc, exp_t1, exp_tz;
    logic signed [7:0] exp_lvl[$];

    function automatic logic [30:0] all_outs();
        return {blk_ready_o, coef_rd_o, coef_addr_o, lvl_clr_o, lvl_we_o, lvl_coef_o,
                t1_cnt_o, t1_stop_o, sum_valid_o, total_coeff_o, trailing_ones_o, total_zeros_o};
    endfunction

    // Reference: TotalCoeff, TotalZeros below the last nonzero, leading unit run (max 3)
    // from the high-frequency end, and remaining nonzeros in reverse order as levels.
    task automatic model_block(input blk_t b);
        int last = -1;
        int nz_seen = 0;
        exp_tc = 0; exp_t1 = 0; exp_tz = 0;
        exp_lvl.delete();
        for (int i = 0; i < 16; i++) if (b[i] != 0) begin last = i; exp_tc++; end
        for (int i = 0; i < last; i++) if (b[i] == 0) exp_tz++;
        for (int i = 15; i >= 0; i--) begin
            if (b[i] != 0) begin
                if (nz_seen == exp_t1 && exp_t1 < 3 && (b[i] == 1 || b[i] == -1)) exp_t1++;
                else exp_lvl.push_back(b[i]);
                nz_seen++;
            end
        end
    endtask

    task automatic gen_block(output blk_t b);
        int r;
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 7);
            if (r < 4)       b[i] = 8'sd0;
            else if (r == 4) b[i] = 8'sd1;
            else if (r == 5) b[i] = -8'sd1;
            else             b[i] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic start_block(input blk_t b, output int t);
        @(negedge clk);
        mem = b;
        got_lvl.delete();
        got_addr.delete();
        clr_cnt = 0;
        blk_valid_i = 1'b1;
        t = -1;
        for (int k = 0; k < 60; k++) begin
            if (blk_ready_o) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        n_tests++;
        if (t < 0) begin
            n_fail++;
            $display("FAIL handshake_timeout: blk_ready_o=%0b required 1 within 60 cycles", blk_ready_o);
        end
        @(posedge clk);
        #1 blk_valid_i = 1'b0;
    endtask

    task automatic finish_block(input string name, input blk_t b, input int t, input int hold);
        int  first = -1;
        bit  lvl_ok;
        logic exp_stop;
        model_block(b);
        exp_stop = (exp_tc > exp_t1) || (exp_t1 == 3);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (sum_valid_o) begin
                first = cyc;
                break;
            end
        end
        n_tests++;
        if (first != t + 19) begin
            n_fail++;
            $display("FAIL %s sum_valid_cycle: got %0d required %0d", name, first, t + 19);
        end
        for (int h = 0; h < hold; h++) begin
            sum_ready_i = 1'b0;
            blk_valid_i = 1'b1;
            n_tests++;
            if ({sum_valid_o, blk_ready_o, total_coeff_o, trailing_ones_o, total_zeros_o} !==
                {1'b1, 1'b0, 5'(exp_tc), 2'(exp_t1), 4'(exp_tz)}) begin
                n_fail++;
                $display("FAIL %s hold_stable: valid=%0b ready=%0b tc=%0d t1=%0d tz=%0d required 1 0 %0d %0d %0d",
                         name, sum_valid_o, blk_ready_o, total_coeff_o, trailing_ones_o, total_zeros_o,
                         exp_tc, exp_t1, exp_tz);
            end
            @(negedge clk);
        end
        blk_valid_i = 1'b0;
        n_tests++;
        if ({total_coeff_o, trailing_ones_o, total_zeros_o, t1_cnt_o, t1_stop_o} !==
            {5'(exp_tc), 2'(exp_t1), 4'(exp_tz), 2'(exp_t1), exp_stop}) begin
            n_fail++;
            $display("FAIL %s summary: tc=%0d t1=%0d tz=%0d t1_cnt=%0d stop=%0b required %0d %0d %0d %0d %0b",
                     name, total_coeff_o, trailing_ones_o, total_zeros_o, t1_cnt_o, t1_stop_o,
                     exp_tc, exp_t1, exp_tz, exp_t1, exp_stop);
        end
        sum_ready_i = 1'b1;
        @(posedge clk);
        #1 sum_ready_i = 1'b0;
        lvl_ok = (got_lvl.size() == exp_lvl.size());
        if (lvl_ok) for (int i = 0; i < exp_lvl.size(); i++) if (got_lvl[i] !== exp_lvl[i]) lvl_ok = 0;
        n_tests++;
        if (!lvl_ok) begin
            n_fail++;
            $display("FAIL %s level_list: got %p required %p", name, got_lvl, exp_lvl);
        end
        n_tests++;
        if (clr_cnt != 1) begin
            n_fail++;
            $display("FAIL %s clr_pulses: got %0d required 1", name, clr_cnt);
        end
        lvl_ok = (got_addr.size() == 16);
        if (lvl_ok) for (int i = 0; i < 16; i++) if (got_addr[i] !== 4'(15 - i)) lvl_ok = 0;
        n_tests++;
        if (!lvl_ok) begin
            n_fail++;
            $display("FAIL %s read_addrs: got %p required 15 down to 0", name, got_addr);
        end
        if (hold > 0) begin
            @(negedge clk);
            n_tests++;
            if ({blk_ready_o, sum_valid_o} !== 2'b10) begin
                n_fail++;
                $display("FAIL %s back_to_idle: ready=%0b valid=%0b required 1 0", name, blk_ready_o, sum_valid_o);
            end
        end
        $display("[TB] %s: tc=%0d t1=%0d tz=%0d levels=%0d hold=%0d", name,
                 exp_tc, exp_t1, exp_tz, exp_lvl.size(), hold);
    endtask

    task automatic run_block(input string name, input blk_t b, input int hold);
        int t;
        start_block(b, t);
        finish_block(name, b, t, hold);
    endtask

    task automatic test_reset();
        rst = 1'b1; blk_valid_i = 1'b0; sum_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (all_outs() !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", all_outs());
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (all_outs() !== 31'h4000_0000) begin
            n_fail++;
            $display("FAIL reset_release: got %h required 40000000", all_outs());
        end
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_directed();
        blk_t b;
        b = '{default: 8'sd0}; b[0] = 3; b[2] = 1; b[3] = -1; b[4] = -1;
        run_block("dir_3_0_1_m1_m1", b, 0);
        b = '{default: 8'sd0}; b[0] = 1; b[1] = 1; b[2] = 1; b[3] = 1;
        run_block("dir_four_ones", b, 1);
        b = '{default: 8'sd0}; b[0] = -1; b[1] = 2; b[2] = 1;
        run_block("dir_m1_2_1", b, 0);
        b = '{default: 8'sd0};
        run_block("dir_all_zero", b, 0);
        b = '{default: 8'sd0}; b[15] = -128; b[0] = 127;
        run_block("dir_extremes", b, 0);
    endtask

    task automatic test_backpressure();
        blk_t b;
        b = '{default: 8'sd0}; b[0] = 7; b[3] = -1; b[9] = 1;
        run_block("backpressure_5", b, 5);
    endtask

    task automatic test_reset_mid_scan();
        blk_t b;
        int   t;
        gen_block(b);
        start_block(b, t);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (all_outs() !== 31'd0) begin
            n_fail++;
            $display("FAIL midscan_rst_cycle: got %h required 0", all_outs());
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (all_outs() !== 31'h4000_0000) begin
            n_fail++;
            $display("FAIL midscan_after_rst: got %h required 40000000", all_outs());
        end
        $display("[TB] reset_mid_scan: aborted at cycle %0d", t + 10);
        b = '{default: 8'sd0}; b[0] = 5;
        run_block("after_reset_5", b, 0);
    endtask

    task automatic test_random();
        blk_t b;
        for (int n = 0; n < 30; n++) begin
            gen_block(b);
            if (n % 5 == 0) for (int i = 8; i < 16; i++) b[i] = 8'sd0;
            run_block($sformatf("rand_%0d", n), b, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        blk_t b;
        int   t_prev, t;
        gen_block(b);
        start_block(b, t_prev);
        finish_block("b2b_0", b, t_prev, 0);
        for (int n = 1; n < 4; n++) begin
            gen_block(b);
            start_block(b, t);
            n_tests++;
            if (t - t_prev != 20) begin
                n_fail++;
                $display("FAIL b2b_period: got %0d required 20", t - t_prev);
            end
            finish_block($sformatf("b2b_%0d", n), b, t, 0);
            t_prev = t;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_scan();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
